knight_tour_checker: RTL and testbench

- Consumer side of the knight-tour solver: takes a stream of board squares, one per move, and checks that they form a legal knight's tour on a DIM x DIM board.
- Squares arrive over a valid/ready handshake. The block keeps a visited bitmap and the last accepted square.
- Reports pass/fail, the first error class and the move index of the first violation.
- Sits downstream of the solver or a testbench stimulus source; a self-checking monitor for solver results.

---
 rtl/knight_tour_checker.sv | 153 +++++++++++++++
 tb/tb_knight_tour_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/knight_tour_checker.sv
// Knight's-tour checker: accepts one board square per handshake and verifies
// that the stream forms a complete legal knight's tour on a DIM x DIM board.
module knight_tour_checker #(
    parameter int DIM = 5,
    parameter int CW  = 3,
    parameter int NW  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    input  logic          end_tour,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [2:0]    err_code,
    output logic [NW-1:0] err_index,
    output logic [NW-1:0] move_count
);

    localparam int SQ = DIM * DIM;
    localparam int IW = $clog2(SQ);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_RANGE   = 3'd1;
    localparam logic [2:0] ERR_MOVE    = 3'd2;
    localparam logic [2:0] ERR_REVISIT = 3'd3;
    localparam logic [2:0] ERR_SHORT   = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCEPT, CHECK, DONE} state_t;

    state_t          state, state_nxt;
    logic [SQ-1:0]   visited;
    logic [CW-1:0]   cur_x, cur_y, last_x, last_y;
    logic            in_range, knight_ok, revisit;
    logic [2:0]      chk_err;
    logic [IW-1:0]   bit_idx;
    logic [NW-1:0]   count_inc;
    logic signed [CW:0] dx, dy, adx, ady;

    assign in_ready = (state == ACCEPT);
    assign busy     = (state == ACCEPT) || (state == CHECK);
    assign done     = (state == DONE);

    // Deltas are one bit wider than the coordinates so no wrap can fake a legal move.
    assign dx  = $signed({1'b0, cur_x}) - $signed({1'b0, last_x});
    assign dy  = $signed({1'b0, cur_y}) - $signed({1'b0, last_y});
    assign adx = dx[CW] ? -dx : dx;
    assign ady = dy[CW] ? -dy : dy;

    assign in_range  = (int'(cur_x) < DIM) && (int'(cur_y) < DIM);
    assign knight_ok = ((adx == (CW+1)'(1)) && (ady == (CW+1)'(2))) ||
                       ((adx == (CW+1)'(2)) && (ady == (CW+1)'(1)));
    assign bit_idx   = IW'(int'(cur_x) * DIM + int'(cur_y));
    assign revisit   = visited[bit_idx];
    assign count_inc = move_count + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        chk_err = ERR_NONE;
        if (!in_range)
            chk_err = ERR_RANGE;
        else if ((move_count != '0) && !knight_ok)
            chk_err = ERR_MOVE;
        else if (revisit)
            chk_err = ERR_REVISIT;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ACCEPT;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_valid)
                        state_nxt = CHECK;
                    else if (end_tour)
                        state_nxt = DONE;
                end
                CHECK: begin
                    if (chk_err != ERR_NONE || count_inc == NW'(SQ))
                        state_nxt = DONE;
                    else
                        state_nxt = ACCEPT;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: the bitmap is plain flops, so it is reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            visited    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            last_x     <= '0;
            last_y     <= '0;
            move_count <= '0;
            err_code   <= ERR_NONE;
            err_index  <= '0;
            pass       <= 1'b0;
        end else if (start) begin
            visited    <= '0;
            last_x     <= '0;
            last_y     <= '0;
            move_count <= '0;
            err_code   <= ERR_NONE;
            err_index  <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_valid) begin
                        cur_x <= in_x;
                        cur_y <= in_y;
                    end else if (end_tour) begin
                        err_code  <= ERR_SHORT;
                        err_index <= move_count;
                        pass      <= 1'b0;
                    end
                end
                CHECK: begin
                    if (chk_err != ERR_NONE) begin
                        err_code  <= chk_err;
                        err_index <= move_count;
                        pass      <= 1'b0;
                    end else begin
                        visited[bit_idx] <= 1'b1;
                        move_count       <= count_inc;
                        last_x           <= cur_x;
                        last_y           <= cur_y;
                        pass             <= (count_inc == NW'(SQ));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_knight_tour_checker.sv
// Directed-vector bench for knight_tour_checker on a 5x5 board.
module tb_knight_tour_checker;

    localparam int DIM = 5;
    localparam int CW  = 3;
    localparam int NW  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_x = '0;
    logic [CW-1:0] in_y = '0;
    logic          end_tour = 1'b0;
    logic          busy, done, pass;
    logic [2:0]    err_code;
    logic [NW-1:0] err_index, move_count;

    int n_vec = 0;
    int n_err = 0;

    // Open 5x5 tour starting (0,0),(2,1),(4,0); consecutive pairs checked by hand.
    int tour_x [25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,1,3,4,2,0,1,3,4,3,1,0,2};
    int tour_y [25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,0,1,3,4,3,1,0,2,4,3,1,2};

    knight_tour_checker #(.DIM(DIM), .CW(CW), .NW(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .end_tour   (end_tour),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_code   (err_code),
        .err_index  (err_index),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one square and hold it until the handshake edge.
    task automatic send(input int x, input int y);
        bit ok = 1'b0;
        @(negedge clk);
        in_x     = CW'(x);
        in_y     = CW'(y);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int p, input int ec,
                                input int ei, input int mc);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, p);
        check({tag, "_err_code"}, err_code, ec);
        check({tag, "_err_index"}, err_index, ei);
        check({tag, "_move_count"}, move_count, mc);
    endtask

    task automatic run_full_tour(input string tag);
        pulse_start();
        for (int i = 0; i < 25; i++) send(tour_x[i], tour_y[i]);
        // Last handshake just happened; the CHECK cycle follows, then DONE.
        @(negedge clk);
        check({tag, "_done_early"}, done, 0);
        check({tag, "_busy_check"}, busy, 1);
        @(negedge clk);
        check({tag, "_busy_end"}, busy, 0);
        check_result(tag, 1, 0, 0, 25);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_err_index"}, err_index, 0);
        check({tag, "_move_count"}, move_count, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst_busy", busy, 0);

        run_full_tour("tour1");

        pulse_start();
        check("restart_clears_done", done, 0);
        send(0, 0); send(5, 1);
        wait_done();
        check_result("range", 0, 1, 1, 1);

        pulse_start();
        send(0, 0); send(7, 7);
        wait_done();
        check_result("range_over_move", 0, 1, 1, 1);

        pulse_start();
        send(0, 0); send(1, 1);
        wait_done();
        check_result("move11", 0, 2, 1, 1);

        pulse_start();
        send(4, 4); send(0, 3);
        wait_done();
        check_result("move_delta4", 0, 2, 1, 1);

        pulse_start();
        send(0, 0); send(2, 1); send(0, 0);
        wait_done();
        check_result("revisit", 0, 3, 2, 2);

        pulse_start();
        send(0, 0); send(1, 2);
        @(negedge clk);
        end_tour = 1'b1;
        wait_done();
        end_tour = 1'b0;
        check_result("short", 0, 4, 2, 2);

        // Reset in the middle of a tour.
        pulse_start();
        send(0, 0); send(2, 1); send(4, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_ready", in_ready, 0);
        run_full_tour("tour2");

        // start coincides with a handshake: square must be dropped.
        pulse_start();
        send(0, 0);
        @(negedge clk);
        @(negedge clk);
        check("pre_same_cycle_count", move_count, 1);
        start    = 1'b1;
        in_valid = 1'b1;
        in_x     = 3'd2;
        in_y     = 3'd1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("same_cycle_count", move_count, 0);
        check("same_cycle_ready", in_ready, 1);
        @(negedge clk);
        check("same_cycle_still_accept", in_ready, 1);
        check("same_cycle_count_hold", move_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation timeout");
    end

endmodule
